// File: rtl/fifo_param_pkg.sv
// fifo_param_pkg: shared widths, scheduler defaults and FSM state type for the FIFO write scheduler.
package fifo_param_pkg;
    localparam int FIFO_WIDTH    = 16;
    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_MAX_BURST = 4;
    localparam int DEF_STALL_TMO = 8;

    typedef enum logic {IDLE, LOCK} state_e;

    // Index width that stays legal for a single-port configuration.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/fifo_wr_sched_if.sv
// fifo_wr_sched_if: producer beats in, single FIFO write port out, plus grant status.
interface fifo_wr_sched_if
    import fifo_param_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DATA_W  = FIFO_WIDTH
);
    logic [NUM_REQ-1:0]             req_valid;
    logic [NUM_REQ-1:0][DATA_W-1:0] req_data;
    logic [NUM_REQ-1:0]             req_last;
    logic [NUM_REQ-1:0]             req_ready;
    logic                           fifo_full;
    logic                           fifo_wr_en;
    logic [DATA_W-1:0]              fifo_wr_data;
    logic [idx_w(NUM_REQ)-1:0]      grant_id;
    logic                           busy;

    modport master (
        output req_valid, req_data, req_last, fifo_full,
        input  req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
    modport slave (
        input  req_valid, req_data, req_last, fifo_full,
        output req_ready, fifo_wr_en, fifo_wr_data, grant_id, busy
    );
endinterface

// File: rtl/fifo_wr_sched_rr_pick.sv
// rr_pick: rotating-priority select of the first request after last_i, wrapping mod NUM_REQ.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IW      = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [IW-1:0]      idx_o,
    output logic               any_o
);
    // Lowest set bit is the wrap-around fallback; lowest set bit above last_i overrides it.
    always_comb begin
        idx_o = '0;
        any_o = |req_i;
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (req_i[j]) idx_o = IW'(j);
        for (int j = NUM_REQ - 1; j >= 0; j--)
            if (req_i[j] && j > int'(last_i)) idx_o = IW'(j);
    end
endmodule

// File: rtl/fifo_wr_sched.sv
// fifo_wr_sched: grants the shared FIFO write port to one producer at a time, releasing on
// last beat, burst limit or owner stall; beats pass through combinationally while locked.
module fifo_wr_sched
    import fifo_param_pkg::*;
#(
    parameter int NUM_REQ   = DEF_NUM_REQ,
    parameter int DATA_W    = FIFO_WIDTH,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int STALL_TMO = DEF_STALL_TMO
) (
    input logic            clk,
    input logic            rstn,
    fifo_wr_sched_if.slave bus
);
    localparam int IW = idx_w(NUM_REQ);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int SW = $clog2(STALL_TMO + 1);

    state_e          state_q;
    logic [IW-1:0]   owner_q, last_q, pick;
    logic [BW-1:0]   beat_q, beat_d;
    logic [SW-1:0]   stall_q, stall_d;
    logic            any, lock, own_v, xfer, done, tmo;

    rr_pick #(.NUM_REQ(NUM_REQ), .IW(IW)) u_pick (
        .req_i  (bus.req_valid),
        .last_i (last_q),
        .idx_o  (pick),
        .any_o  (any)
    );

    assign lock  = state_q == LOCK;
    assign own_v = bus.req_valid[owner_q];
    assign xfer  = lock && own_v && !bus.fifo_full;

    // Full-while-valid cycles neither count as stall nor advance the burst.
    always_comb begin
        beat_d  = xfer ? beat_q + 1'b1 : beat_q;
        stall_d = (lock && !own_v) ? stall_q + 1'b1 : '0;
        done    = xfer && (bus.req_last[owner_q] || beat_d == BW'(MAX_BURST));
        tmo     = lock && stall_d == SW'(STALL_TMO);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= IW'(NUM_REQ - 1);
            beat_q  <= '0;
            stall_q <= '0;
        end else if (!lock) begin
            beat_q  <= '0;
            stall_q <= '0;
            if (any) begin
                state_q <= LOCK;
                owner_q <= pick;
            end
        end else begin
            beat_q  <= beat_d;
            stall_q <= stall_d;
            if (done || tmo) begin
                state_q <= IDLE;
                last_q  <= owner_q;
            end
        end
    end

    always_comb begin
        bus.req_ready          = '0;
        bus.req_ready[owner_q] = lock && !bus.fifo_full;
        bus.fifo_wr_en         = xfer;
        bus.fifo_wr_data       = lock ? bus.req_data[owner_q] : DATA_W'(0);
        bus.grant_id           = owner_q;
        bus.busy               = lock;
    end
endmodule
